bus_req_queue: RTL and testbench
================================

BUS_REQ_QUEUE -- requirements
Module: bus_req_queue

Interface
REQ-001 The block SHALL have parameter NUM_PROC, default 4, number of requesting processors.
REQ-002 The block SHALL have parameter DEPTH, default 8, FIFO entries; a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; every flop is clocked on its rising edge.
REQ-004 The block SHALL have port rst_l, input, 1, reset; synchronous and active-low.
REQ-005 The block SHALL have port request, input, NUM_PROC, per-processor request strobe.
REQ-006 The block SHALL have port request_dest, input, NUM_PROC x DEST_W, per-processor destination id, where DEST_W = $clog2(NUM_PROC)+1.
REQ-007 The block SHALL have port request_ack, output, NUM_PROC, registered one-hot: request accepted.
REQ-008 The block SHALL have port request_nack, output, NUM_PROC, registered: request refused, retry required.
REQ-009 The block SHALL have port out_valid, output, 1, head entry present.
REQ-010 The block SHALL have port out_dest, output, DEST_W, head entry destination id.
REQ-011 The block SHALL have port out_ready, input, 1, downstream bus accepts the head entry.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-013 Each cycle the block SHALL select at most one winner among the asserted request bits, round-robin, searching upward from rr_ptr with wrap.
REQ-014 The winner SHALL be enqueued when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle (push-on-full-with-pop).
REQ-015 request_ack[i] SHALL assert in the cycle after the cycle in which requester i was enqueued.
REQ-016 Every asserted request bit that is not enqueued SHALL get request_nack asserted in the next cycle; this includes the losers and a winner refused for fullness.
REQ-017 request_ack and request_nack SHALL never both be high for the same requester, and each SHALL be low for any requester that did not request.
REQ-018 rr_ptr SHALL advance to (winner+1) mod NUM_PROC only on a successful enqueue; otherwise it holds.
REQ-019 out_valid SHALL equal (count != 0); out_dest SHALL be the head entry, combinational from the storage; a pop SHALL occur when out_valid && out_ready.
REQ-020 out_dest SHALL hold stable while out_valid && !out_ready.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH)+1 bits, with the MSB as the wrap bit; full and empty SHALL be derived from the pointer compare.
REQ-022 On a simultaneous push and pop, count SHALL stay unchanged; on a push and pop while empty, the entry SHALL be written and out_valid SHALL assert the following cycle (no fall-through).
REQ-023 Entries SHALL be popped in strict FIFO order, with no loss and no duplication.

Reset
REQ-024 While rst_l is low at a clk edge: pointers, count, and rr_ptr SHALL be 0; request_ack and request_nack SHALL be 0; out_valid SHALL be 0.
REQ-025 A reset asserted mid-operation SHALL discard all queued entries, and requests presented in that cycle SHALL get neither ack nor nack.
REQ-026 Storage contents SHALL not require reset.

Configuration
REQ-027 With BUS_REQ_QUEUE_STATS_EN defined, the block SHALL add output nack_total (32 bits), incremented by the popcount of request_nack each cycle, saturating at all-ones, and reset to 0.
REQ-028 Without BUS_REQ_QUEUE_STATS_EN, the nack_total port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package bus_pkg SHALL hold the DEST_W function or localparam and the dest_t typedef, shared with the downstream bus block.
REQ-030 The round-robin selector SHALL be sub-module rr_arbiter (NUM_PROC request in, one-hot grant out, ptr in); the FIFO storage SHALL be inline.

Verification
REQ-031 The bench SHALL cover single request: request=4'b0100, dest=2, out_ready=0 -> next cycle request_ack=4'b0100, count=1, out_valid=1, out_dest=2.
REQ-032 The bench SHALL cover contention: request=4'b1111 for 4 cycles, rr_ptr=0 -> acks go 0,1,2,3 in order, and the non-winners are nacked each cycle.
REQ-033 The bench SHALL cover full: DEPTH=8, fill 8 entries, out_ready=0, request=4'b0001 -> request_nack=4'b0001, count stays 8; with out_ready=1 the same cycle -> ack, count stays 8.
REQ-034 The bench SHALL cover drain and wrap: fill dests 0..7, pop all, refill 3 entries -> out_dest order is preserved across the pointer wrap, and count returns to 0 between phases.
REQ-035 The bench SHALL cover mid-operation reset: 5 entries queued, rst_l=0 for one cycle -> count=0, out_valid=0, no ack or nack; with STATS_EN, nack_total=0.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared destination-id width helper and type for the request queue and downstream bus
package bus_pkg;

    localparam int NUM_PROC_DEFAULT = 4;

    // One extra bit beyond the processor index leaves room for non-processor targets.
    function automatic int dest_w(input int num_proc);
        return $clog2(num_proc) + 1;
    endfunction

    typedef logic [dest_w(NUM_PROC_DEFAULT)-1:0] dest_t;

endpackage

// File: rtl/bus_req_queue_if.sv
// rtl/bus_req_queue_if.sv - request/response and head-of-queue signals; nack_total present with BUS_REQ_QUEUE_STATS_EN
interface bus_req_queue_if #(
    parameter int NUM_PROC = 4,
    parameter int DEPTH    = 8
) ();
    import bus_pkg::*;

    localparam int DEST_W = dest_w(NUM_PROC);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [NUM_PROC-1:0]             request;
    logic [NUM_PROC-1:0][DEST_W-1:0] request_dest;
    logic [NUM_PROC-1:0]             request_ack;
    logic [NUM_PROC-1:0]             request_nack;
    logic                            out_valid;
    logic [DEST_W-1:0]               out_dest;
    logic                            out_ready;
    logic [CNT_W-1:0]                count;
`ifdef BUS_REQ_QUEUE_STATS_EN
    logic [31:0]                     nack_total;

    modport master (
        output request, request_dest, out_ready,
        input  request_ack, request_nack, out_valid, out_dest, count, nack_total
    );
    modport slave (
        input  request, request_dest, out_ready,
        output request_ack, request_nack, out_valid, out_dest, count, nack_total
    );
`else
    modport master (
        output request, request_dest, out_ready,
        input  request_ack, request_nack, out_valid, out_dest, count
    );
    modport slave (
        input  request, request_dest, out_ready,
        output request_ack, request_nack, out_valid, out_dest, count
    );
`endif

endinterface

// File: rtl/bus_req_queue_rr_arbiter.sv
// rtl/bus_req_queue_rr_arbiter.sv - round-robin selector: one-hot grant searching upward from ptr_i with wrap
module rr_arbiter #(
    parameter int NUM_PROC = 4,
    parameter int PW       = 2
) (
    input  logic [NUM_PROC-1:0] req_i,
    input  logic [PW-1:0]       ptr_i,
    output logic [NUM_PROC-1:0] grant_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            idx = PW'((int'(ptr_i) + i) % NUM_PROC);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_req_queue.sv
// rtl/bus_req_queue.sv - round-robin arbitrated request FIFO with ack/nack; BUS_REQ_QUEUE_STATS_EN adds nack_total
module bus_req_queue
    import bus_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst_l,
    bus_req_queue_if.slave  bus
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int DEST_W = dest_w(NUM_PROC);

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_PROC-1:0]  ack_q, ack_d;
    logic [NUM_PROC-1:0]  nack_q, nack_d;
    logic [DEST_W-1:0]    mem_q [DEPTH];

    logic [NUM_PROC-1:0]  grant;
    logic [PW-1:0]        win_idx;
    logic                 empty, full, push, pop;

    rr_arbiter #(
        .NUM_PROC (NUM_PROC),
        .PW       (PW)
    ) u_rr_arbiter (
        .req_i   (bus.request),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && bus.out_ready;
        // A full queue still accepts when the head leaves in the same cycle.
        push    = (|grant) && (!full || pop);

        win_idx = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (grant[i]) begin
                win_idx = PW'(i);
            end
        end

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (win_idx == PW'(NUM_PROC - 1)) ? '0 : win_idx + 1'b1;
        end

        ack_d  = push ? grant : '0;
        nack_d = bus.request & ~ack_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
            ack_q    <= '0;
            nack_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
        end
    end

    // Storage is left unreset; occupancy is fully described by the pointers.
    always_ff @(posedge clk) begin
        if (rst_l && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.request_dest[win_idx];
        end
    end

    assign bus.count        = wr_ptr_q - rd_ptr_q;
    assign bus.out_valid    = !empty;
    assign bus.out_dest     = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.request_ack  = ack_q;
    assign bus.request_nack = nack_q;

`ifdef BUS_REQ_QUEUE_STATS_EN
    logic [31:0] nack_total_q, nack_total_d;
    logic [32:0] nack_sum;

    always_comb begin
        nack_sum     = {1'b0, nack_total_q} + 33'($countones(nack_q));
        nack_total_d = nack_sum[32] ? '1 : nack_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            nack_total_q <= '0;
        end else begin
            nack_total_q <= nack_total_d;
        end
    end

    assign bus.nack_total = nack_total_q;
`endif

endmodule

// File: tb/tb_bus_req_queue.sv
// tb/tb_bus_req_queue.sv - self-checking bench: directed table, hand sequences and random traffic against a queue model
module tb_bus_req_queue;

    localparam int NP    = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_l;

    bus_req_queue_if #(.NUM_PROC(NP), .DEPTH(DEPTH)) ifc ();

    bus_req_queue #(.NUM_PROC(NP), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;

    int          mq[$];
    int          rr;
    logic [3:0]  eack;
    logic [3:0]  enack;
    longint      etot;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       rstl;
        logic [3:0] ack;
        logic [3:0] nack;
        int         cnt;
        int         dest;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string tag, input string what, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d at %0t", tag, what, act, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] req, input logic [11:0] dst,
                        input logic rdy, input logic rstl);
        int win;
        bit do_pop;
        bit do_push;
        ifc.request      = req;
        ifc.request_dest = dst;
        ifc.out_ready    = rdy;
        rst_l            = rstl;
        win = -1;
        if (!rstl) begin
            mq.delete();
            rr    = 0;
            eack  = '0;
            enack = '0;
            etot  = 0;
        end else begin
            etot = etot + $countones(enack);
            if (etot > 64'hFFFF_FFFF) etot = 64'hFFFF_FFFF;
            for (int k = 0; k < NP; k++) begin
                if (win < 0 && ((req >> ((rr + k) % NP)) & 4'd1) != 0) win = (rr + k) % NP;
            end
            do_pop  = (mq.size() > 0) && rdy;
            do_push = (win >= 0) && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(int'((dst >> (3 * win)) & 12'd7));
                rr = (win + 1) % NP;
            end
            eack  = do_push ? 4'(1 << win) : 4'd0;
            enack = req & ~eack;
        end
        @(posedge clk);
        #1;
        chk(tag, "request_ack", ifc.request_ack, eack);
        chk(tag, "request_nack", ifc.request_nack, enack);
        chk(tag, "count", ifc.count, mq.size());
        chk(tag, "out_valid", ifc.out_valid, mq.size() != 0);
        if (mq.size() != 0) chk(tag, "out_dest", ifc.out_dest, mq[0]);
`ifdef BUS_REQ_QUEUE_STATS_EN
        chk(tag, "nack_total", ifc.nack_total, etot);
`endif
    endtask

    initial begin
        logic [11:0] dall;
        n_chk  = 0;
        n_fail = 0;
        rr     = 0;
        eack   = '0;
        enack  = '0;
        etot   = 0;
        rst_l            = 1'b0;
        ifc.request      = '0;
        ifc.request_dest = '0;
        ifc.out_ready    = 1'b0;
        dall = {3'd3, 3'd2, 3'd1, 3'd0};

        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, -1};
        tbl[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 1,  2};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, -1};
        tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4'b1110, 1,  0};
        tbl[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 4'b1101, 2,  0};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 4'b1011, 3,  0};
        tbl[6]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 4'b0111, 4,  0};
        tbl[7]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000, 5,  0};
        tbl[8]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000, 6,  0};
        tbl[9]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000, 7,  0};
        tbl[10] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000, 8,  0};
        tbl[11] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0001, 8,  0};
        tbl[12] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 8,  1};

        for (int i = 0; i < 13; i++) begin
            step("tbl", tbl[i].req, dall, tbl[i].rdy, tbl[i].rstl);
            chk("tbl_const", "request_ack", ifc.request_ack, tbl[i].ack);
            chk("tbl_const", "request_nack", ifc.request_nack, tbl[i].nack);
            chk("tbl_const", "count", ifc.count, tbl[i].cnt);
            if (tbl[i].dest >= 0) chk("tbl_const", "out_dest", ifc.out_dest, tbl[i].dest);
        end

        // drain and wrap
        step("wrap_rst", 4'b0000, 12'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step("wrap_fill", 4'b0001, 12'(k), 1'b0, 1'b1);
        chk("wrap_full", "count", ifc.count, 8);
        for (int k = 0; k < 8; k++) begin
            chk("wrap_drain_head", "out_dest", ifc.out_dest, k);
            step("wrap_drain", 4'b0000, 12'd0, 1'b1, 1'b1);
        end
        chk("wrap_empty", "count", ifc.count, 0);
        for (int k = 0; k < 3; k++) step("wrap_refill", 4'b0001, 12'(k + 5), 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("wrap_redrain_head", "out_dest", ifc.out_dest, k + 5);
            step("wrap_redrain", 4'b0000, 12'd0, 1'b1, 1'b1);
        end
        chk("wrap_empty2", "count", ifc.count, 0);

        // mid-operation reset
        step("mid_rst0", 4'b0000, 12'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step("mid_fill", 4'b0011, dall, 1'b0, 1'b1);
        chk("mid_fill", "count", ifc.count, 5);
        step("mid_rst", 4'b1111, dall, 1'b1, 1'b0);
        chk("mid_rst_const", "count", ifc.count, 0);
        chk("mid_rst_const", "out_valid", ifc.out_valid, 0);
        chk("mid_rst_const", "ack_nack", {ifc.request_ack, ifc.request_nack}, 0);
`ifdef BUS_REQ_QUEUE_STATS_EN
        chk("mid_rst_const", "nack_total", ifc.nack_total, 0);
`endif
        step("mid_after", 4'b0000, 12'd0, 1'b0, 1'b1);
        chk("mid_after_const", "ack_nack", {ifc.request_ack, ifc.request_nack}, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step("rand", 4'($urandom), 12'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 99) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
